pcie_fifo_arbiter: RTL and testbench
====================================

# pcie_fifo_arbiter

Round-robin read scheduler that drains four 12-bit input FIFOs (one per requester/virtual channel) into a single shared output FIFO in the PCIE datapath. It issues `read_enable` pops to the input FIFOs and `write_enable` pushes to the output FIFO. It throttles on the output FIFO's `almost_full`/`full` flags and bounds each requester to a burst of consecutive words. A sticky error state captures output-FIFO overflow.

## Interface
- `DATA_WIDTH`, 12, word width; matches the FIFO data width.
- `BURST`, 4, maximum consecutive pops granted to one requester before rotating; legal range 1..15.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enable`  in  1  level; 1 allows scheduling.
- `fifo_empty`  in  4  `empty` flag of input FIFO i at bit i.
- `fifo_data`  in  4*DATA_WIDTH  `data_out` of input FIFO i at `[i*DATA_WIDTH +: DATA_WIDTH]`; valid the cycle after its pop.
- `out_almost_full`  in  1  output FIFO `almost_full` (count ≥ depth-1).
- `out_full`  in  1  output FIFO `full`.
- `out_error`  in  1  output FIFO `error`.
- `pop`  out  4  one-hot `read_enable` to input FIFO i; at most one bit high.
- `push`  out  1  `write_enable` to output FIFO.
- `data_out`  out  DATA_WIDTH  word to the output FIFO; 0 whenever `push`=0.
- `grant`  out  2  index of the currently granted requester.
- `state`  out  2  IDLE=0, ACTIVE=1, PAUSE=2, ERROR=3.
- `push_count`  out  8  total pushes since reset; wraps 255→0.

## Operation
- Reset values: `state`=IDLE, `grant`=0, burst counter=0, `pop`=0, `push`=0, `data_out`=0, `push_count`=0, pipeline valid=0.
- Pop condition (cycle c): all of the following hold:
  - `state`=ACTIVE;
  - `fifo_empty[grant]`=0;
  - `out_almost_full`=0 and `out_full`=0;
  - `out_error`=0.
- When the pop condition holds, `pop[grant]`=1 combinationally.
- The pop is registered as valid/index for the push in cycle c+1.
- Push (cycle c+1): `push`=1, `data_out`=`fifo_data` slice of the registered index, `push_count`+=1.
- Rotation, evaluated at each edge:
  - The burst counter increments on a pop.
  - If the counter reaches BURST, or `fifo_empty[grant]`=1, `grant` moves to the next index after `grant` (mod 4) whose `fifo_empty` bit is 0. The counter clears.
  - If no other requester is non-empty and the current one is non-empty with the burst exhausted, `grant` stays and the counter clears.
  - If all are empty, `grant` holds.
- State transitions (priority order):
  - any state, `out_error`=1 → ERROR; sticky until `reset`;
  - ACTIVE/PAUSE with `enable`=0 → IDLE;
  - IDLE with `enable`=1 and any `fifo_empty` bit 0 → ACTIVE;
  - ACTIVE with `out_almost_full` or `out_full` → PAUSE;
  - ACTIVE with all `fifo_empty`=1 → IDLE;
  - PAUSE with both output flags 0 → ACTIVE.
- Leaving ACTIVE does not cancel a push already in flight; it still completes in the next cycle.
- Exception: entry to ERROR suppresses `push` and `pop` in the same cycle and every cycle afterwards.

## Timing
- Pop-to-push latency is exactly 1 cycle; back-to-back pops give one push per cycle.
- `fifo_empty` from an input FIFO reflects a pop at c by cycle c+1, so consecutive pops of one FIFO are safe.
- Throttle margin: `out_almost_full` blocks new pops, leaving one free slot for the in-flight push. No push is ever issued while `out_full`=1 in the same cycle.
- Grant switch costs no bubble: the next requester may be popped in the cycle after rotation.
- An asynchronous `reset` mid-burst drops any in-flight push immediately; all outputs return to their reset values without waiting for `clk`.

## Test plan
- Fill only FIFO 2 with 3 words (0x0A1, 0x0A2, 0x0A3), `enable`=1: `pop[2]` high for 3 consecutive cycles; pushes 0x0A1..0x0A3 each one cycle later; `grant`=2; then `state`→IDLE; `push_count`=3.
- All four FIFOs hold 6 words, BURST=4: `grant` sequence is 0×4, 1×4, 2×4, 3×4, 0×2, 1×2, 2×2, 3×2; 24 pushes with no idle cycles; `push_count`=24.
- Raise `out_almost_full` mid-burst: `pop` drops the same cycle; exactly one further push occurs; `state`=PAUSE. On release, popping resumes on the same `grant` and the burst count is kept.
- Assert `out_error` while active: `state`=ERROR next edge; `pop`=0 and `push`=0 thereafter even after `out_error` falls; only `reset` returns `state` to IDLE.
- Assert `reset` for one half-cycle during a push: `push`, `pop`, `data_out`, `grant`, `push_count` read 0 immediately, before the next clock edge.
- Drive 260 single-word transfers: `push_count` wraps to 4.

Source files
------------

// File: rtl/pcie_fifo_arbiter_if.sv
// Bundle of the scheduler's control, data and status signals between the
// four input FIFOs, the shared output FIFO and the arbiter itself.
interface pcie_fifo_arbiter_if #(
    parameter int DATA_WIDTH = 12
);
    logic                      enable;
    logic [3:0]                fifo_empty;
    logic [4*DATA_WIDTH-1:0]   fifo_data;
    logic                      out_almost_full;
    logic                      out_full;
    logic                      out_error;
    logic [3:0]                pop;
    logic                      push;
    logic [DATA_WIDTH-1:0]     data_out;
    logic [1:0]                grant;
    logic [1:0]                state;
    logic [7:0]                push_count;

    // Arbiter side: consumes FIFO flags/data, produces pops, pushes and status.
    modport slave (
        input  enable, fifo_empty, fifo_data, out_almost_full, out_full, out_error,
        output pop, push, data_out, grant, state, push_count
    );

    // Environment side: owns the FIFOs and observes the arbiter.
    modport master (
        output enable, fifo_empty, fifo_data, out_almost_full, out_full, out_error,
        input  pop, push, data_out, grant, state, push_count
    );
endinterface

// File: rtl/pcie_fifo_arbiter.sv
// Round-robin read scheduler: drains four input FIFOs into one shared output
// FIFO, bounded bursts per requester, throttled by the output FIFO flags and
// latched into a sticky ERROR state on output-FIFO overflow.
module pcie_fifo_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int BURST      = 4
) (
    input logic               clk,
    input logic               reset,
    pcie_fifo_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_grant;
    logic [1:0] w_grant_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_inc;
    logic [3:0] w_cnt_nxt;
    logic [2:0] w_next;
    logic       r_valid;
    logic [1:0] r_idx;
    logic [7:0] r_push_count;
    logic       w_pop_any;
    logic       w_push;
    logic       w_throttle;

    // Nearest non-empty requester after cur (mod 4): {found, index}.
    function automatic logic [2:0] next_ready(input logic [1:0] cur,
                                              input logic [3:0] empty);
        logic [1:0] cand;
        next_ready = 3'b000;
        for (int k = 3; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (!empty[cand]) begin
                next_ready = {1'b1, cand};
            end else begin
                next_ready = next_ready;
            end
        end
    endfunction

    assign w_throttle = bus.out_almost_full | bus.out_full;

    // Pop/push decode: pop only when active with room; an in-flight push is
    // dropped the moment the output FIFO reports an error.
    always_comb begin
        w_pop_any = 1'b0;
        w_push    = 1'b0;
        if ((r_state == ST_ACTIVE) && !bus.fifo_empty[r_grant] && !w_throttle && !bus.out_error) begin
            w_pop_any = 1'b1;
        end else begin
            w_pop_any = 1'b0;
        end
        if (r_valid && (r_state != ST_ERROR) && !bus.out_error) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    assign bus.pop        = w_pop_any ? (4'b0001 << r_grant) : 4'b0000;
    assign bus.push       = w_push;
    assign bus.data_out   = w_push ? bus.fifo_data[r_idx*DATA_WIDTH +: DATA_WIDTH]
                                   : {DATA_WIDTH{1'b0}};
    assign bus.grant      = r_grant;
    assign bus.state      = r_state;
    assign bus.push_count = r_push_count;

    // Next-state logic; an output-FIFO error overrides everything and sticks.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.out_error) begin
            w_state_nxt = ST_ERROR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.enable && !(&bus.fifo_empty)) begin
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (!bus.enable) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_throttle) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (&bus.fifo_empty) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.enable) begin
                        w_state_nxt = ST_IDLE;
                    end else if (!w_throttle) begin
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_ERROR: begin
                    w_state_nxt = ST_ERROR;
                end
                default: begin
                    w_state_nxt = ST_ERROR;
                end
            endcase
        end
    end

    // Burst counting and rotation: move on when the burst is spent or the
    // granted FIFO ran dry; stay put when nobody else has data.
    always_comb begin
        w_cnt_inc   = r_cnt + {3'b000, w_pop_any};
        w_next      = next_ready(r_grant, bus.fifo_empty);
        w_cnt_nxt   = w_cnt_inc;
        w_grant_nxt = r_grant;
        if ((w_cnt_inc == 4'(BURST)) || bus.fifo_empty[r_grant]) begin
            w_cnt_nxt = 4'd0;
            if (w_next[2]) begin
                w_grant_nxt = w_next[1:0];
            end else begin
                w_grant_nxt = r_grant;
            end
        end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_grant_nxt = r_grant;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant pointer and burst counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= 2'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // One-stage pop-to-push pipeline: remembers which FIFO to forward next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_idx   <= 2'd0;
        end else begin
            r_valid <= w_pop_any;
            r_idx   <= r_grant;
        end
    end

    // Free-running count of accepted pushes, wrapping at 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_push_count <= 8'd0;
        end else if (w_push) begin
            r_push_count <= r_push_count + 8'd1;
        end else begin
            r_push_count <= r_push_count;
        end
    end

endmodule

// File: tb/tb_pcie_fifo_arbiter.sv
// Self-checking bench for pcie_fifo_arbiter: behavioural input FIFOs plus a
// scoreboard of expected pop order and pushed words, filled when the FIFOs
// are loaded and drained as the DUT pops and pushes.
module tb_pcie_fifo_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pcie_fifo_arbiter_if #(.DATA_WIDTH(12)) bus ();

    pcie_fifo_arbiter #(.DATA_WIDTH(12), .BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Input FIFO models.
    logic [11:0] mq0[$];
    logic [11:0] mq1[$];
    logic [11:0] mq2[$];
    logic [11:0] mq3[$];
    logic [3:0]  emp = 4'hF;
    logic [47:0] fd  = 48'h0;

    // Scoreboard.
    int          exp_pop[$];
    logic [11:0] exp_data[$];

    assign bus.fifo_empty = emp;
    assign bus.fifo_data  = fd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: data_out valid the cycle after a pop, empty updated by then.
    always @(posedge clk) begin
        if (bus.pop[0] && mq0.size() > 0) fd[11:0]  <= mq0.pop_front();
        if (bus.pop[1] && mq1.size() > 0) fd[23:12] <= mq1.pop_front();
        if (bus.pop[2] && mq2.size() > 0) fd[35:24] <= mq2.pop_front();
        if (bus.pop[3] && mq3.size() > 0) fd[47:36] <= mq3.pop_front();
        emp <= {mq3.size() == 0, mq2.size() == 0, mq1.size() == 0, mq0.size() == 0};
    end

    // Scoreboard monitor: pop order/grant, pushed data, idle data_out.
    always @(negedge clk) begin
        int pidx;
        int e;
        logic [11:0] ed;
        if (!reset) begin
            if (bus.pop !== 4'b0000) begin
                pidx = 0;
                for (int k = 0; k < 4; k++) if (bus.pop[k]) pidx = k;
                n_checks++;
                if (exp_pop.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_order: got pop=%b with no pop expected", bus.pop);
                end else begin
                    e = exp_pop.pop_front();
                    if (!$onehot(bus.pop) || pidx != e || int'(bus.grant) != e) begin
                        n_fail++;
                        $display("FAIL pop_order: got pop=%b grant=%0d, expected requester %0d",
                                 bus.pop, bus.grant, e);
                    end
                end
            end
            n_checks++;
            if (bus.push === 1'b1) begin
                if (exp_data.size() == 0) begin
                    n_fail++;
                    $display("FAIL push_data: got push of %h with no push expected", bus.data_out);
                end else begin
                    ed = exp_data.pop_front();
                    if (bus.data_out !== ed || bus.out_full !== 1'b0) begin
                        n_fail++;
                        $display("FAIL push_data: got %h (out_full=%b), expected %h",
                                 bus.data_out, bus.out_full, ed);
                    end
                end
            end else if (bus.data_out !== 12'h000) begin
                n_fail++;
                $display("FAIL idle_data: got %h while push=0, expected 000", bus.data_out);
            end
        end
    end

    task automatic load(input int i, input logic [11:0] w);
        case (i)
            0:       mq0.push_back(w);
            1:       mq1.push_back(w);
            2:       mq2.push_back(w);
            default: mq3.push_back(w);
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.enable = 1'b0; bus.out_almost_full = 1'b0;
        bus.out_full = 1'b0; bus.out_error = 1'b0;
        mq0.delete(); mq1.delete(); mq2.delete(); mq3.delete();
        exp_pop.delete(); exp_data.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Waits until every expected pop/push was seen and the DUT is back in IDLE.
    task automatic wait_drain(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (bus.state == 2'd0 && exp_data.size() == 0 && exp_pop.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd0 || bus.grant !== 2'd0 || bus.pop !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: state=%0d grant=%0d pop=%b, expected 0 0 0000",
                     bus.state, bus.grant, bus.pop);
        end
        n_checks++;
        if (bus.push !== 1'b0 || bus.data_out !== 12'h000 || bus.push_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: push=%b data=%h count=%0d, expected 0 000 0",
                     bus.push, bus.data_out, bus.push_count);
        end
    endtask

    task automatic test_single_fifo();
        int run;
        int max_run;
        bit ok;
        do_reset();
        load(2, 12'h0A1); load(2, 12'h0A2); load(2, 12'h0A3);
        for (int k = 0; k < 3; k++) exp_pop.push_back(2);
        exp_data.push_back(12'h0A1); exp_data.push_back(12'h0A2); exp_data.push_back(12'h0A3);
        bus.enable = 1'b1;
        run = 0; max_run = 0; ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.pop === 4'b0100) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (bus.state == 2'd0 && exp_pop.size() == 0 && exp_data.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || max_run != 3) begin
            n_fail++;
            $display("FAIL single_fifo_run: drained=%0d longest pop[2] run=%0d, expected 1 and 3", ok, max_run);
        end
        n_checks++;
        if (bus.grant !== 2'd2 || bus.state !== 2'd0 || bus.push_count !== 8'd3) begin
            n_fail++;
            $display("FAIL single_fifo_end: grant=%0d state=%0d count=%0d, expected 2 0 3",
                     bus.grant, bus.state, bus.push_count);
        end
    endtask

    task automatic test_round_robin();
        int first;
        int last;
        int npop;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 6; k++) load(i, 12'(i * 256 + k));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                for (int k = (r == 0 ? 0 : 4); k < (r == 0 ? 4 : 6); k++) begin
                    exp_pop.push_back(i);
                    exp_data.push_back(12'(i * 256 + k));
                end
        bus.enable = 1'b1;
        first = -1; last = -1; npop = 0;
        for (int c = 0; c < 40 && npop < 16; c++) begin
            @(negedge clk);
            if (bus.pop !== 4'b0000) begin
                if (first < 0) first = c;
                npop++;
                if (npop == 16) last = c;
            end
        end
        // Burst-driven rotations cost no bubble: 16 pops in 16 cycles.
        n_checks++;
        if (last < 0 || last - first != 15) begin
            n_fail++;
            $display("FAIL rr_no_bubble: 16 pops spanned %0d cycles, expected 16", last - first + 1);
        end
        wait_drain(40, ok);
        n_checks++;
        if (!ok || bus.push_count !== 8'd24) begin
            n_fail++;
            $display("FAIL rr_total: drained=%0d count=%0d, expected 1 and 24", ok, bus.push_count);
        end
    endtask

    task automatic test_throttle();
        int seen;
        int pushes;
        bit ok;
        do_reset();
        for (int k = 0; k < 6; k++) begin load(1, 12'h100 + 12'(k)); load(3, 12'h300 + 12'(k)); end
        for (int k = 0; k < 4; k++) begin exp_pop.push_back(1); exp_data.push_back(12'h100 + 12'(k)); end
        for (int k = 0; k < 4; k++) begin exp_pop.push_back(3); exp_data.push_back(12'h300 + 12'(k)); end
        for (int k = 4; k < 6; k++) begin exp_pop.push_back(1); exp_data.push_back(12'h100 + 12'(k)); end
        for (int k = 4; k < 6; k++) begin exp_pop.push_back(3); exp_data.push_back(12'h300 + 12'(k)); end
        bus.enable = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(negedge clk);
            if (bus.pop === 4'b0010) seen++;
        end
        @(posedge clk); #1;
        bus.out_almost_full = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.pop !== 4'b0000 || bus.push !== 1'b1) begin
            n_fail++;
            $display("FAIL throttle_edge: pop=%b push=%b, expected 0000 and 1", bus.pop, bus.push);
        end
        pushes = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.push === 1'b1) pushes++;
        end
        n_checks++;
        if (pushes != 0 || bus.state !== 2'd2 || bus.grant !== 2'd1) begin
            n_fail++;
            $display("FAIL throttle_pause: extra pushes=%0d state=%0d grant=%0d, expected 0 2 1",
                     pushes, bus.state, bus.grant);
        end
        @(posedge clk); #1;
        bus.out_almost_full = 1'b0;
        wait_drain(40, ok);
        n_checks++;
        if (!ok || bus.push_count !== 8'd12) begin
            n_fail++;
            $display("FAIL throttle_resume: drained=%0d count=%0d, expected 1 and 12", ok, bus.push_count);
        end
    endtask

    task automatic test_error();
        bit bad;
        do_reset();
        for (int k = 0; k < 8; k++) load(0, 12'h500 + 12'(k));
        exp_pop.push_back(0);
        bus.enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.pop !== 4'b0000) break;
        end
        @(posedge clk); #1;
        bus.out_error = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.pop !== 4'b0000 || bus.push !== 1'b0) begin
            n_fail++;
            $display("FAIL error_entry: pop=%b push=%b, expected 0000 and 0", bus.pop, bus.push);
        end
        @(posedge clk); #1;
        bus.out_error = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd3) begin
            n_fail++;
            $display("FAIL error_state: state=%0d, expected 3", bus.state);
        end
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.pop !== 4'b0000 || bus.push !== 1'b0 || bus.state !== 2'd3) bad = 1'b1;
        end
        n_checks++;
        if (bad || bus.push_count !== 8'd0 || exp_pop.size() != 0) begin
            n_fail++;
            $display("FAIL error_sticky: activity=%0d count=%0d pending pops=%0d, expected 0 0 0",
                     bad, bus.push_count, exp_pop.size());
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL error_clear: state=%0d after reset, expected 0", bus.state);
        end
    endtask

    task automatic test_async_reset();
        int npush;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            load(3, 12'h3C0 + 12'(k));
            exp_pop.push_back(3);
            exp_data.push_back(12'h3C0 + 12'(k));
        end
        bus.enable = 1'b1;
        npush = 0;
        for (int c = 0; c < 20 && npush < 2; c++) begin
            @(negedge clk);
            if (bus.push === 1'b1) npush++;
        end
        n_checks++;
        if (npush != 2 || bus.push_count !== 8'd1 || bus.grant !== 2'd3) begin
            n_fail++;
            $display("FAIL areset_pre: pushes=%0d count=%0d grant=%0d, expected 2 1 3",
                     npush, bus.push_count, bus.grant);
        end
        #1;
        reset = 1'b1;
        bus.enable = 1'b0;
        #1;
        n_checks++;
        if (bus.push !== 1'b0 || bus.pop !== 4'b0000 || bus.data_out !== 12'h000 ||
            bus.grant !== 2'd0 || bus.push_count !== 8'd0 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_now: push=%b pop=%b data=%h grant=%0d count=%0d state=%0d, expected all 0",
                     bus.push, bus.pop, bus.data_out, bus.grant, bus.push_count, bus.state);
        end
        mq0.delete(); mq1.delete(); mq2.delete(); mq3.delete();
        exp_pop.delete(); exp_data.delete();
        #2;
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        bus.enable = 1'b1;
        for (int t = 0; t < 260; t++) begin
            @(posedge clk); #1;
            load(t % 4, 12'(t));
            exp_pop.push_back(t % 4);
            exp_data.push_back(12'(t));
            wait_drain(15, ok);
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL wrap_timeout: transfer %0d never completed", t);
                break;
            end
            if (t == 254) begin
                n_checks++;
                if (bus.push_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: count=%0d, expected 255", bus.push_count);
                end
            end
            if (t == 255) begin
                n_checks++;
                if (bus.push_count !== 8'd0) begin
                    n_fail++;
                    $display("FAIL wrap_256: count=%0d, expected 0", bus.push_count);
                end
            end
        end
        n_checks++;
        if (bus.push_count !== 8'd4) begin
            n_fail++;
            $display("FAIL wrap_260: count=%0d, expected 4", bus.push_count);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.enable = 1'b0; bus.out_almost_full = 1'b0;
        bus.out_full = 1'b0; bus.out_error = 1'b0;
        test_reset();
        test_single_fifo();
        test_round_robin();
        test_throttle();
        test_error();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
